// File: rtl/barrido_display_if.sv
`default_nettype none
// barrido_display_if: pattern inputs, scan enable and display outputs of the scan controller.
// Revision 1.0
interface barrido_display_if;
    logic       enable;
    logic [7:0] catodo1;
    logic [7:0] catodo2;
    logic [7:0] catodo3;
    logic [7:0] catodo4;
    logic [7:0] catodo;
    logic [3:0] anodo;
    logic       frame_tick;

    modport master (
        output enable, catodo1, catodo2, catodo3, catodo4,
        input  catodo, anodo, frame_tick
    );

    modport slave (
        input  enable, catodo1, catodo2, catodo3, catodo4,
        output catodo, anodo, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/barrido_display.sv
`default_nettype none
// barrido_display: four-digit seven-segment scan controller with per-frame pattern snapshot.
// Define BARRIDO_GAP_EN to blank the first GAP cycles of every digit slot. Revision 1.0
module barrido_display #(
    parameter int unsigned DIV = 50000,
    parameter int unsigned GAP = 16
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    barrido_display_if.slave bus
);
    localparam int unsigned   CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        APAGADO = 2'd0,
        BLANCO  = 2'd1,
        MUESTRA = 2'd2
    } state_t;

    state_t          r_st;
    state_t          w_st_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [1:0]      r_dig;
    logic [1:0]      w_dig_nxt;
    logic [3:0][7:0] r_sh;
    logic [3:0][7:0] w_sh_nxt;
    logic [3:0][7:0] w_inputs;
    logic [7:0]      r_catodo;
    logic [7:0]      w_catodo_nxt;
    logic [3:0]      r_anodo;
    logic [3:0]      w_anodo_nxt;
    logic            r_tick;
    logic            w_tick_nxt;

`ifdef BARRIDO_GAP_EN
    localparam logic [CW-1:0] C_GAP = CW'(GAP);
`else
    logic [31:0] w_unused_gap;
    assign w_unused_gap = GAP;
`endif

    assign w_inputs = {bus.catodo4, bus.catodo3, bus.catodo2, bus.catodo1};

    // Outputs are derived from the next-state values so they change on the same edge as the state.
    always_comb begin
        w_st_nxt     = r_st;
        w_cnt_nxt    = r_cnt;
        w_dig_nxt    = r_dig;
        w_sh_nxt     = r_sh;
        w_tick_nxt   = 1'b0;
        w_catodo_nxt = 8'hFF;
        w_anodo_nxt  = 4'hF;

        if (!bus.enable) begin
            w_st_nxt  = APAGADO;
            w_cnt_nxt = '0;
            w_dig_nxt = 2'd0;
        end else begin
            if (r_st == APAGADO) begin
                w_sh_nxt  = w_inputs;
                w_cnt_nxt = '0;
                w_dig_nxt = 2'd0;
            end else if (r_cnt == C_LAST) begin
                w_cnt_nxt = '0;
                w_dig_nxt = r_dig + 2'd1;
                if (r_dig == 2'd3) begin
                    w_sh_nxt   = w_inputs;
                    w_tick_nxt = 1'b1;
                end
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
`ifdef BARRIDO_GAP_EN
            w_st_nxt = (w_cnt_nxt < C_GAP) ? BLANCO : MUESTRA;
`else
            w_st_nxt = MUESTRA;
`endif
        end

        if (w_st_nxt == MUESTRA) begin
            w_catodo_nxt = w_sh_nxt[w_dig_nxt];
            w_anodo_nxt  = ~(4'b0001 << w_dig_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st     <= APAGADO;
            r_cnt    <= '0;
            r_dig    <= 2'd0;
            r_sh     <= {4{8'hFF}};
            r_catodo <= 8'hFF;
            r_anodo  <= 4'hF;
            r_tick   <= 1'b0;
        end else begin
            r_st     <= w_st_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dig    <= w_dig_nxt;
            r_sh     <= w_sh_nxt;
            r_catodo <= w_catodo_nxt;
            r_anodo  <= w_anodo_nxt;
            r_tick   <= w_tick_nxt;
        end
    end

    assign bus.catodo     = r_catodo;
    assign bus.anodo      = r_anodo;
    assign bus.frame_tick = r_tick;
endmodule
`default_nettype wire
